// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART slot core.
// Contents: register indices, RD status bit positions and the TX/RX
// state encodings used by wb_uart_core.
package uart_pkg;

    // Word-addressed register indices
    localparam logic [4:0] REG_RD   = 5'd0;
    localparam logic [4:0] REG_DVSR = 5'd1;
    localparam logic [4:0] REG_WR   = 5'd2;
    localparam logic [4:0] REG_RM   = 5'd3;
    localparam logic [4:0] REG_CTRL = 5'd4;

    // Status bit positions inside the RD word
    localparam int BIT_RX_EMPTY  = 8;
    localparam int BIT_TX_FULL   = 9;
    localparam int BIT_OVERRUN   = 10;
    localparam int BIT_FRAME_ERR = 11;
    localparam int BIT_LOOPBACK  = 12;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used for both UART byte queues.
// Ports: clk, rst (sync active-high), push/din, pop/dout (head, no
// read latency), full, empty.
// A push while full is dropped unless a pop happens in the same cycle,
// in which case both take effect; a pop while empty is ignored.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = cnt_q[AW];
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rptr_q];

    // Effective push/pop and next pointer/count values
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/wb_uart_core.sv
// Wishbone slave UART core: 8N1 link, programmable baud divisor,
// 16-entry TX/RX FIFOs, sticky overrun/frame error flags.
// Ports: CLK_I, RST_I (sync active-high), CYC_I/STB_I/WE_I/ADDR_I/DAT_I
// bus inputs, DAT_O/ACK_O registered bus outputs, rx serial in, tx serial out.
// Optional feature macro: UART_LOOPBACK_EN (CTRL[0] routes tx to the RX
// FSM and holds the tx pin high; CTRL reads back in RD[12]).
module wb_uart_core
    import uart_pkg::*;
#(
    parameter int FIFO_AW  = 4,
    parameter int DVSR_RST = 53
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [4:0]  ADDR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    input  logic        rx,
    output logic        tx
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [10:0] dvsr_q, dvsr_d;
    logic [10:0] cnt_q, cnt_d;
    logic        rx_s1_q, rx_s2_q;
    logic        tx_q, tx_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic [3:0]  tx_s_q, tx_s_d;
    logic [2:0]  tx_n_q, tx_n_d;
    logic [7:0]  tx_b_q, tx_b_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [3:0]  rx_s_q, rx_s_d;
    logic [2:0]  rx_n_q, rx_n_d;
    logic [7:0]  rx_b_q, rx_b_d;
    logic        ovr_q, ovr_d, ferr_q, ferr_d;
    logic        accept, wr_dvsr, wr_tx, wr_rm, tick, lb, rx_in;
    logic        tx_pop, rx_push, ferr_set, ovr_set;
    logic        txf_full, txf_empty, rxf_full, rxf_empty;
    logic [7:0]  txf_dout, rxf_dout;
    logic [31:0] rd_word;
    logic        dat_unused;

    assign dat_unused = ^DAT_I[31:11];
    assign ACK_O      = ack_q;
    assign DAT_O      = dat_q;
    assign accept     = CYC_I & STB_I & ~ack_q;
    assign wr_dvsr    = accept & WE_I & (ADDR_I == REG_DVSR);
    assign wr_tx      = accept & WE_I & (ADDR_I == REG_WR);
    assign wr_rm      = accept & WE_I & (ADDR_I == REG_RM);
    assign tick       = (cnt_q == dvsr_q);
    // In loopback the receiver listens to the internal line, not the pin
    assign rx_in      = lb ? tx_q : rx_s2_q;

`ifdef UART_LOOPBACK_EN
    logic ctrl_q, ctrl_d, tx_pin_q, tx_pin_d;
    assign lb = ctrl_q;
    assign tx = tx_pin_q;

    // Loopback control register and registered tx pin
    always_comb begin
        ctrl_d   = (accept & WE_I & (ADDR_I == REG_CTRL)) ? DAT_I[0] : ctrl_q;
        tx_pin_d = ctrl_d ? 1'b1 : tx_d;
    end

    // Loopback flops
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ctrl_q   <= 1'b0;
            tx_pin_q <= 1'b1;
        end else begin
            ctrl_q   <= ctrl_d;
            tx_pin_q <= tx_pin_d;
        end
    end
`else
    assign lb = 1'b0;
    assign tx = tx_q;
`endif

    uart_fifo #(.DW(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk(CLK_I), .rst(RST_I), .push(wr_tx), .pop(tx_pop), .din(DAT_I[7:0]),
        .dout(txf_dout), .full(txf_full), .empty(txf_empty)
    );

    uart_fifo #(.DW(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk(CLK_I), .rst(RST_I), .push(rx_push), .pop(wr_rm), .din(rx_b_d),
        .dout(rxf_dout), .full(rxf_full), .empty(rxf_empty)
    );

    // Bus response, divisor, baud tick counter and sticky flags
    always_comb begin
        rd_word = {19'd0, lb, ferr_q, ovr_q, txf_full, rxf_empty,
                   rxf_empty ? 8'd0 : rxf_dout};
        ack_d   = accept;
        dat_d   = (accept & ~WE_I & (ADDR_I == REG_RD)) ? rd_word : 32'd0;
        dvsr_d  = wr_dvsr ? DAT_I[10:0] : dvsr_q;
        if (wr_dvsr | tick) begin
            cnt_d = 11'd0;
        end else begin
            cnt_d = cnt_q + 11'd1;
        end
        // Popping while full in the same cycle makes room, so no overrun
        ovr_set = rx_push & rxf_full & ~wr_rm;
        ovr_d   = ovr_set | (ovr_q & ~wr_rm);
        ferr_d  = ferr_set | (ferr_q & ~wr_rm);
    end

    // Transmit FSM: start, 8 data bits LSB first, stop; 16 ticks per bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!txf_empty) begin
                    tx_pop = 1'b1; tx_b_d = txf_dout; tx_s_d = 4'd0;
                    tx_d = 1'b0; tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tick && tx_s_q == 4'd15) begin
                    tx_s_d = 4'd0; tx_n_d = 3'd0;
                    tx_d = tx_b_q[0]; tx_state_d = TX_DATA;
                end else if (tick) begin
                    tx_s_d = tx_s_q + 4'd1;
                end else begin
                    tx_s_d = tx_s_q;
                end
            end
            TX_DATA: begin
                if (tick && tx_s_q == 4'd15) begin
                    tx_s_d = 4'd0;
                    tx_b_d = {1'b0, tx_b_q[7:1]};
                    if (tx_n_q == 3'd7) begin
                        tx_d = 1'b1; tx_state_d = TX_STOP;
                    end else begin
                        tx_n_d = tx_n_q + 3'd1; tx_d = tx_b_q[1];
                    end
                end else if (tick) begin
                    tx_s_d = tx_s_q + 4'd1;
                end else begin
                    tx_s_d = tx_s_q;
                end
            end
            TX_STOP: begin
                if (tick && tx_s_q == 4'd15) begin
                    tx_s_d = 4'd0;
                    // Chain straight into the next start bit when data waits
                    if (!txf_empty) begin
                        tx_pop = 1'b1; tx_b_d = txf_dout;
                        tx_d = 1'b0; tx_state_d = TX_START;
                    end else begin
                        tx_d = 1'b1; tx_state_d = TX_IDLE;
                    end
                end else if (tick) begin
                    tx_s_d = tx_s_q + 4'd1;
                end else begin
                    tx_s_d = tx_s_q;
                end
            end
            default: begin
                tx_d = 1'b1; tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Receive FSM: mid-bit sampling after a 7-tick start qualification
    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_in) begin
                    rx_s_d = 4'd0; rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (tick && rx_s_q == 4'd7) begin
                    rx_s_d = 4'd0; rx_n_d = 3'd0;
                    // Line back high at mid start bit means it was a glitch
                    rx_state_d = rx_in ? RX_IDLE : RX_DATA;
                end else if (tick) begin
                    rx_s_d = rx_s_q + 4'd1;
                end else begin
                    rx_s_d = rx_s_q;
                end
            end
            RX_DATA: begin
                if (tick && rx_s_q == 4'd15) begin
                    rx_s_d = 4'd0;
                    rx_b_d = {rx_in, rx_b_q[7:1]};
                    if (rx_n_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_n_d = rx_n_q + 3'd1;
                    end
                end else if (tick) begin
                    rx_s_d = rx_s_q + 4'd1;
                end else begin
                    rx_s_d = rx_s_q;
                end
            end
            RX_STOP: begin
                if (tick && rx_s_q == 4'd15) begin
                    rx_s_d = 4'd0; rx_push = 1'b1;
                    ferr_set = ~rx_in; rx_state_d = RX_IDLE;
                end else if (tick) begin
                    rx_s_d = rx_s_q + 4'd1;
                end else begin
                    rx_s_d = rx_s_q;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Core state registers
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ack_q <= 1'b0; dat_q <= 32'd0;
            dvsr_q <= 11'(DVSR_RST); cnt_q <= 11'd0;
            rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; tx_q <= 1'b1;
            tx_state_q <= TX_IDLE; tx_s_q <= 4'd0; tx_n_q <= 3'd0; tx_b_q <= 8'd0;
            rx_state_q <= RX_IDLE; rx_s_q <= 4'd0; rx_n_q <= 3'd0; rx_b_q <= 8'd0;
            ovr_q <= 1'b0; ferr_q <= 1'b0;
        end else begin
            ack_q <= ack_d; dat_q <= dat_d;
            dvsr_q <= dvsr_d; cnt_q <= cnt_d;
            rx_s1_q <= rx; rx_s2_q <= rx_s1_q; tx_q <= tx_d;
            tx_state_q <= tx_state_d; tx_s_q <= tx_s_d; tx_n_q <= tx_n_d; tx_b_q <= tx_b_d;
            rx_state_q <= rx_state_d; rx_s_q <= rx_s_d; rx_n_q <= rx_n_d; rx_b_q <= rx_b_d;
            ovr_q <= ovr_d; ferr_q <= ferr_d;
        end
    end

endmodule

// File: tb/tb_wb_uart_core.sv
// Self-checking bench for wb_uart_core: table of register accesses after
// reset, then hand-written serial sequences for TX/RX, overflow, framing,
// glitch rejection, optional loopback and mid-frame reset.
module tb_wb_uart_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        ack;
    logic        rx_pin = 1'b1;
    logic        tx_pin;

    int n_checks = 0;
    int n_errors = 0;

    wb_uart_core dut (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
        .ADDR_I(addr), .DAT_I(dat_i), .DAT_O(dat_o), .ACK_O(ack),
        .rx(rx_pin), .tx(tx_pin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone transfer; ACK must arrive exactly one cycle after STB and last one cycle
    task automatic wb_xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        int lat;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat_i = d; lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ack && lat < 8);
        rd = dat_o;
        check("ack_latency", 32'(lat), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_single_cycle", {31'd0, ack}, 32'd0);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, a, d, unused_rd);
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] rd);
        wb_xfer(1'b0, a, 32'd0, rd);
    endtask

    // Drive one 8N1 frame at 64 clocks per bit; a bad stop is held low only
    // long enough to be sampled, then the line idles high
    task automatic rx_send(input logic [7:0] b, input logic good_stop);
        @(posedge clk); #1;
        rx_pin = 1'b0;
        repeat (64) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (64) @(posedge clk); #1;
        end
        if (good_stop) begin
            rx_pin = 1'b1;
            repeat (64) @(posedge clk); #1;
        end else begin
            rx_pin = 1'b0;
            repeat (44) @(posedge clk); #1;
            rx_pin = 1'b1;
            repeat (84) @(posedge clk); #1;
        end
    endtask

    // Capture one frame from the tx pin, sampling at mid-bit
    task automatic tx_capture(output logic [7:0] b, output logic ok);
        int n;
        n = 0; ok = 1'b1; b = 8'd0;
        while (tx_pin !== 1'b0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) begin
            ok = 1'b0;
        end else begin
            repeat (32) @(posedge clk); #1;
            if (tx_pin !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (64) @(posedge clk); #1;
                b[i] = tx_pin;
            end
            repeat (64) @(posedge clk); #1;
            if (tx_pin !== 1'b1) ok = 1'b0;
        end
    endtask

    // Count cycles on which the tx pin is low over a window
    task automatic tx_low_count(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (tx_pin !== 1'b1) lows++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        logic        ok;
        int          lows;

        vecs[0]  = '{1'b0, 5'd0,  32'd0,          32'h0000_0100};
        vecs[1]  = '{1'b0, 5'd1,  32'd0,          32'h0};
        vecs[2]  = '{1'b0, 5'd2,  32'd0,          32'h0};
        vecs[3]  = '{1'b0, 5'd3,  32'd0,          32'h0};
        vecs[4]  = '{1'b0, 5'd4,  32'd0,          32'h0};
        vecs[5]  = '{1'b0, 5'd31, 32'd0,          32'h0};
        vecs[6]  = '{1'b1, 5'd9,  32'hFFFF_FFFF,  32'h0};
        vecs[7]  = '{1'b0, 5'd9,  32'd0,          32'h0};
        vecs[8]  = '{1'b1, 5'd3,  32'd0,          32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'd0,          32'h0000_0100};
        vecs[10] = '{1'b1, 5'd1,  32'd3,          32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'd0,          32'h0000_0100};

        // Reset state
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_tx", {31'd0, tx_pin}, 32'd1);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_dat", dat_o, 32'd0);

        // Register map table (ends with DVSR=3)
        for (int i = 0; i < 12; i++) begin
            wb_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (!vecs[i].we) check("table_read", rd, vecs[i].exp);
        end

        // TX of 0xA5: bits 1,0,1,0,0,1,0,1 then stop
        check("tx_idle", {31'd0, tx_pin}, 32'd1);
        wb_write(5'd2, 32'h0000_00A5);
        tx_capture(b, ok);
        check("tx_a5_byte", {24'd0, b}, 32'h0000_00A5);
        check("tx_a5_frame", {31'd0, ok}, 32'd1);

        // RX of 0x3C, then pop
        rx_send(8'h3C, 1'b1);
        wb_read(5'd0, rd);
        check("rx_3c", rd, 32'h0000_003C);
        wb_write(5'd3, 32'd0);
        wb_read(5'd0, rd);
        check("rx_pop_empty", rd, 32'h0000_0100);

        // Short low pulse on rx is rejected
        @(posedge clk); #1 rx_pin = 1'b0;
        repeat (16) @(posedge clk); #1 rx_pin = 1'b1;
        repeat (200) @(posedge clk);
        wb_read(5'd0, rd);
        check("rx_glitch", rd, 32'h0000_0100);

        // Low stop bit: byte kept, frame_err set, RM clears it
        rx_send(8'h81, 1'b0);
        wb_read(5'd0, rd);
        check("rx_frame_err", rd, 32'h0000_0881);
        wb_write(5'd3, 32'd0);
        wb_read(5'd0, rd);
        check("rx_frame_clr", rd, 32'h0000_0100);

        // 17 bytes without popping: 16 kept, overrun set, cleared by RM
        for (int i = 0; i < 17; i++) rx_send(8'(i * 37 + 5), 1'b1);
        wb_read(5'd0, rd);
        check("rx_overrun", rd, 32'h0000_0405);
        for (int i = 0; i < 16; i++) begin
            wb_write(5'd3, 32'd0);
            wb_read(5'd0, rd);
            if (i < 15) check("rx_fifo_order", rd, {24'd0, 8'((i + 1) * 37 + 5)});
            else        check("rx_fifo_drained", rd, 32'h0000_0100);
        end

        // Burst of writes during the first frame. Byte 1 leaves the FIFO at
        // once, so 17 writes fill it; an 18th is dropped.
        fork
            begin
                for (int i = 0; i < 17; i++) wb_write(5'd2, {24'd0, 8'(8'h10 + i)});
                wb_read(5'd0, rd);
                check("tx_full", rd, 32'h0000_0300);
                wb_write(5'd2, 32'h0000_00EE);
            end
            begin
                logic [7:0] cb;
                logic       cok;
                for (int k = 0; k < 17; k++) begin
                    tx_capture(cb, cok);
                    check("tx_burst_byte", {24'd0, cb}, {24'd0, 8'(8'h10 + k)});
                    check("tx_burst_frame", {31'd0, cok}, 32'd1);
                end
            end
        join
        tx_low_count(1000, lows);
        check("tx_drop_when_full", 32'(lows), 32'd0);

`ifdef UART_LOOPBACK_EN
        // Loopback: byte returns through RX, pin stays high
        wb_write(5'd4, 32'd1);
        wb_read(5'd0, rd);
        check("lb_ctrl_readback", rd, 32'h0000_1100);
        wb_write(5'd2, 32'h0000_005A);
        tx_low_count(700, lows);
        check("lb_pin_high", 32'(lows), 32'd0);
        wb_read(5'd0, rd);
        check("lb_rx_byte", rd, 32'h0000_105A);
        wb_write(5'd3, 32'd0);
        wb_write(5'd4, 32'd0);
        wb_read(5'd0, rd);
        check("lb_off", rd, 32'h0000_0100);
`endif

        // Reset in the middle of a frame of zeros
        wb_write(5'd2, 32'h0000_0000);
        repeat (300) @(posedge clk); #1;
        check("mid_frame_low", {31'd0, tx_pin}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_frame_tx", {31'd0, tx_pin}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        wb_read(5'd0, rd);
        check("reset_mid_frame_rd", rd, 32'h0000_0100);
        tx_low_count(200, lows);
        check("reset_tx_quiet", 32'(lows), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
